// File: rtl/instruction_execute.sv
// -----------------------------------------------------------------------------
// instruction_execute
//
// Execute stage of a five-stage RISC-V style pipeline, together with the
// EX/MEM pipeline register that follows it.
//
// The stage does the following:
//   - It resolves operand forwarding from the writeback and memory stages.
//   - It selects the second ALU operand, either the register value or the
//     immediate.
//   - It runs the ALU.
//   - It computes the branch/jump target and the redirect request, both
//     combinationally, so that fetch can act in the same cycle.
//   - It registers the result and the memory/writeback controls for the
//     memory stage.
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous, active-high reset of the EX/MEM register
//   RD1E, RD2E          register-file operands from ID/EX
//   PCE, PCPlus4E       PC of this instruction and PC+4
//   ImmExtE             sign-extended immediate
//   RdE                 destination register index
//   RegWriteE           register write enable
//   MemWriteE           data memory write enable
//   JumpE, BranchE      jump / conditional branch
//   ALUSrcE             1: the second ALU operand is ImmExtE
//   ResultSrcE          writeback result select (passed through)
//   ALUControlE         ALU operation select
//   ForwardAE/BE        forwarding selects from the hazard unit
//   ResultW             writeback-stage result, used for forwarding
//   PCSrcE, PCTargetE   combinational redirect request and target to fetch
//   ALUResultM, WriteDataM, PCPlus4M, RdM,
//   RegWriteM, MemWriteM, ResultSrcM
//                       EX/MEM register outputs
// -----------------------------------------------------------------------------
module instruction_execute (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] RD1E,
    input  logic [31:0] RD2E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [31:0] ImmExtE,
    input  logic [4:0]  RdE,

    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        JumpE,
    input  logic        BranchE,
    input  logic        ALUSrcE,
    input  logic [1:0]  ResultSrcE,
    input  logic [2:0]  ALUControlE,

    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic [31:0] ResultW,

    output logic        PCSrcE,
    output logic [31:0] PCTargetE,

    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM,
    output logic [31:0] PCPlus4M,
    output logic [4:0]  RdM,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic [1:0]  ResultSrcM
);

    // Forwarding selects. Code 11 is unused and behaves like 00, which
    // means "take the register-file value".
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // ALU operation codes. Codes 100, 110 and 111 are unused and produce 0.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // -------------------------------------------------------------------------
    // Execute-stage combinational signals
    // -------------------------------------------------------------------------
    logic [31:0] src_a_e;
    logic [31:0] write_data_e;
    logic [31:0] src_b_e;
    logic [31:0] alu_result_e;
    logic        zero_e;

    // EX/MEM register state and its next-state values.
    logic [31:0] alu_result_q,  alu_result_d;
    logic [31:0] write_data_q,  write_data_d;
    logic [31:0] pc_plus4_q,    pc_plus4_d;
    logic [4:0]  rd_q,          rd_d;
    logic        reg_write_q,   reg_write_d;
    logic        mem_write_q,   mem_write_d;
    logic [1:0]  result_src_q,  result_src_d;

    // -------------------------------------------------------------------------
    // Operand forwarding.
    // The memory-stage value comes from this block's own registered result.
    // That way a back-to-back dependent instruction sees the result of the
    // previous cycle without any extra wiring.
    // -------------------------------------------------------------------------
    // NOTE: every combinational output is given a value on every path (a
    // default arm or a leading default), so no latch can be inferred.
    always_comb begin
        case (ForwardAE)
            FWD_WB:  src_a_e = ResultW;
            FWD_MEM: src_a_e = alu_result_q;
            default: src_a_e = RD1E;
        endcase
    end

    always_comb begin
        case (ForwardBE)
            FWD_WB:  write_data_e = ResultW;
            FWD_MEM: write_data_e = alu_result_q;
            default: write_data_e = RD2E;
        endcase
    end

    // The store data is the forwarded operand, captured before the immediate
    // mux, so that stores see forwarded values too.
    assign src_b_e = ALUSrcE ? ImmExtE : write_data_e;

    // -------------------------------------------------------------------------
    // ALU. All arithmetic wraps modulo 2^32, and no carry or overflow flag
    // is produced.
    // -------------------------------------------------------------------------
    always_comb begin
        case (ALUControlE)
            ALU_ADD: alu_result_e = src_a_e + src_b_e;
            ALU_SUB: alu_result_e = src_a_e - src_b_e;
            ALU_AND: alu_result_e = src_a_e & src_b_e;
            ALU_OR:  alu_result_e = src_a_e | src_b_e;
            ALU_SLT: alu_result_e = {31'd0, ($signed(src_a_e) < $signed(src_b_e))};
            default: alu_result_e = 32'd0;
        endcase
    end

    assign zero_e = (alu_result_e == 32'd0);

    // -------------------------------------------------------------------------
    // Redirect to fetch.
    // This path is purely combinational and does not depend on reset. A
    // branch is taken when the comparison, done by subtraction, gives zero.
    // -------------------------------------------------------------------------
    assign PCTargetE = PCE + ImmExtE;
    assign PCSrcE    = (BranchE & zero_e) | JumpE;

    // -------------------------------------------------------------------------
    // EX/MEM register. It has no stall and no enable, so it loads every
    // cycle. Bubbles arrive with all-zero controls and pass through
    // unchanged, which keeps RegWriteM and MemWriteM low.
    // -------------------------------------------------------------------------
    always_comb begin
        alu_result_d = alu_result_e;
        write_data_d = write_data_e;
        pc_plus4_d   = PCPlus4E;
        rd_d         = RdE;
        reg_write_d  = RegWriteE;
        mem_write_d  = MemWriteE;
        result_src_d = ResultSrcE;
    end

    // NOTE: sequential state uses non-blocking assignments only. All
    // registers therefore sample their next-state values from the same
    // edge, regardless of statement order.
    // NOTE: reset is checked first. An instruction that is in flight when
    // reset is high is discarded, and the datapath registers are cleared
    // together with the controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_result_q <= 32'd0;
            write_data_q <= 32'd0;
            pc_plus4_q   <= 32'd0;
            rd_q         <= 5'd0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 2'b00;
        end else begin
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_plus4_q   <= pc_plus4_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
        end
    end

    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign PCPlus4M   = pc_plus4_q;
    assign RdM        = rd_q;
    assign RegWriteM  = reg_write_q;
    assign MemWriteM  = mem_write_q;
    assign ResultSrcM = result_src_q;

endmodule

// File: tb/tb_instruction_execute.sv
// -----------------------------------------------------------------------------
// tb_instruction_execute
//
// Directed, self-checking bench for instruction_execute.
//
// For every clock edge the bench computes the expected EX/MEM contents from
// its own behavioural model and pushes them to a scoreboard queue. After the
// edge it pops that entry and compares it with the DUT outputs. The
// combinational redirect outputs are checked in the same cycle, before the
// edge.
// -----------------------------------------------------------------------------
module tb_instruction_execute;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
    } exmem_t;

    logic        clk;
    logic        reset;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [4:0]  RdE;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ResultW;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;

    int     checks   = 0;
    int     failures = 0;
    exmem_t sb[$];

    // The model's own view of ALUResultM, used for memory-stage forwarding.
    logic [31:0] model_alu_m = 32'd0;

    instruction_execute dut (
        .clk         (clk),
        .reset       (reset),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E),
        .ImmExtE     (ImmExtE),
        .RdE         (RdE),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .JumpE       (JumpE),
        .BranchE     (BranchE),
        .ALUSrcE     (ALUSrcE),
        .ResultSrcE  (ResultSrcE),
        .ALUControlE (ALUControlE),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .ResultW     (ResultW),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .PCPlus4M    (PCPlus4M),
        .RdM         (RdM),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guards against a hung run.
    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] reg_val);
        if (sel == 2'b01)      return ResultW;
        else if (sel == 2'b10) return model_alu_m;
        else                   return reg_val;
    endfunction

    function automatic logic [31:0] alu_model(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [32:0] wide;
        case (op)
            3'b000:  begin wide = {1'b0, a} + {1'b0, b}; return wide[31:0]; end
            3'b001:  return a + (~b + 32'd1);
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  begin
                // Signed compare: the operands differ in sign -> a is negative.
                if (a[31] != b[31]) return {31'd0, a[31]};
                else                return {31'd0, (a < b)};
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic clear_inputs();
        RD1E = 32'd0; RD2E = 32'd0; PCE = 32'd0; PCPlus4E = 32'd0; ImmExtE = 32'd0;
        RdE = 5'd0; RegWriteE = 1'b0; MemWriteE = 1'b0; JumpE = 1'b0; BranchE = 1'b0;
        ALUSrcE = 1'b0; ResultSrcE = 2'b00; ALUControlE = 3'b000;
        ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = 32'd0;
    endtask

    // Checks the combinational redirect outputs against the given values.
    task automatic check_redirect(input string tag, input logic exp_src, input logic [31:0] exp_tgt);
        #1;
        check({tag, "_pcsrc"},  {31'd0, PCSrcE}, {31'd0, exp_src});
        check({tag, "_target"}, PCTargetE,       exp_tgt);
    endtask

    // Predicts, advances one edge, then pops the prediction and compares.
    task automatic tick(input string tag);
        exmem_t e, got_exp;
        logic [31:0] wd;
        if (reset) begin
            e = '0;
        end else begin
            wd    = fwd(ForwardBE, RD2E);
            e.alu = alu_model(ALUControlE, fwd(ForwardAE, RD1E), ALUSrcE ? ImmExtE : wd);
            e.wd  = wd;
            e.pc4 = PCPlus4E;
            e.rd  = RdE;
            e.rw  = RegWriteE;
            e.mw  = MemWriteE;
            e.rs  = ResultSrcE;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        got_exp = sb.pop_front();
        model_alu_m = got_exp.alu;
        check({tag, "_alu"}, ALUResultM,           got_exp.alu);
        check({tag, "_wd"},  WriteDataM,           got_exp.wd);
        check({tag, "_pc4"}, PCPlus4M,             got_exp.pc4);
        check({tag, "_rd"},  {27'd0, RdM},         {27'd0, got_exp.rd});
        check({tag, "_rw"},  {31'd0, RegWriteM},   {31'd0, got_exp.rw});
        check({tag, "_mw"},  {31'd0, MemWriteM},   {31'd0, got_exp.mw});
        check({tag, "_rs"},  {30'd0, ResultSrcM},  {30'd0, got_exp.rs});
    endtask

    initial begin
        clear_inputs();

        // Reset with live inputs: the outputs must clear and stay cleared.
        reset = 1'b1;
        RD1E = 32'd1; RD2E = 32'd2; RdE = 5'd9; RegWriteE = 1'b1; MemWriteE = 1'b1;
        PCPlus4E = 32'h10; ResultSrcE = 2'b01;
        tick("reset0");
        tick("reset1");

        // Add: 5 + 7 -> 12, written to x3.
        reset = 1'b0;
        clear_inputs();
        RD1E = 32'd5; RD2E = 32'd7; RdE = 5'd3; RegWriteE = 1'b1;
        tick("add");
        check("add_lit", ALUResultM, 32'd12);

        // Signed set-less-than: -1 < 1 -> 1.
        clear_inputs();
        RD1E = 32'hFFFF_FFFF; RD2E = 32'd1; ALUControlE = 3'b101; RdE = 5'd4; RegWriteE = 1'b1;
        tick("slt");
        check("slt_lit", ALUResultM, 32'd1);

        // Signed set-less-than in the reverse direction: 1 < -1 -> 0.
        RD1E = 32'd1; RD2E = 32'hFFFF_FFFF;
        tick("slt_rev");

        // Subtraction wraps: 0 - 1 -> 0xFFFFFFFF.
        clear_inputs();
        RD1E = 32'd0; RD2E = 32'd1; ALUControlE = 3'b001; RdE = 5'd5; RegWriteE = 1'b1;
        tick("sub");
        check("sub_lit", ALUResultM, 32'hFFFF_FFFF);

        // Addition wraps with the carry discarded.
        clear_inputs();
        RD1E = 32'hFFFF_FFFF; RD2E = 32'd2; RegWriteE = 1'b1;
        tick("add_wrap");

        // Forwarding: produce 20, then forward it (MEM) plus ResultW (WB) = 24.
        clear_inputs();
        RD1E = 32'd10; RD2E = 32'd10; RdE = 5'd6; RegWriteE = 1'b1;
        tick("pre_fwd");
        clear_inputs();
        RD1E = 32'h111; RD2E = 32'h222; ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'd4;
        RdE = 5'd7; RegWriteE = 1'b1;
        tick("fwd");
        check("fwd_alu_lit", ALUResultM, 32'd24);
        check("fwd_wd_lit",  WriteDataM, 32'd4);

        // Forward select 11 falls back to the register values.
        clear_inputs();
        RD1E = 32'd3; RD2E = 32'd4; ForwardAE = 2'b11; ForwardBE = 2'b11; ResultW = 32'd99;
        tick("fwd11");

        // Immediate operand with AND and OR.
        clear_inputs();
        RD1E = 32'h0000_F0F0; RD2E = 32'h1234_5678; ImmExtE = 32'h0000_FF00; ALUSrcE = 1'b1;
        ALUControlE = 3'b010;
        tick("and_imm");
        ALUControlE = 3'b011;
        tick("or_imm");

        // beq taken: 9 - 9 = 0.
        clear_inputs();
        RD1E = 32'd9; RD2E = 32'd9; BranchE = 1'b1; ALUControlE = 3'b001;
        PCE = 32'h100; ImmExtE = 32'hFFFF_FFF8;
        check_redirect("beq_taken", 1'b1, 32'h0000_00F8);
        tick("beq_taken");

        // beq not taken: 9 - 8 != 0.
        RD2E = 32'd8;
        check_redirect("beq_not", 1'b0, 32'h0000_00F8);
        tick("beq_not");

        // Unused ALU codes give 0, so a branch is taken under them.
        for (int c = 0; c < 3; c++) begin
            clear_inputs();
            RD1E = 32'hDEAD_BEEF; RD2E = 32'h0BAD_F00D; BranchE = 1'b1;
            PCE = 32'h200; ImmExtE = 32'h40; RegWriteE = 1'b1;
            ALUControlE = (c == 0) ? 3'b100 : ((c == 1) ? 3'b110 : 3'b111);
            check_redirect("unused_op", 1'b1, 32'h0000_0240);
            tick("unused_op");
        end

        // jal: redirect now, and the link data arrives next edge.
        clear_inputs();
        JumpE = 1'b1; PCPlus4E = 32'h44; ResultSrcE = 2'b10; RdE = 5'd1; RegWriteE = 1'b1;
        PCE = 32'h40; ImmExtE = 32'h20; RD1E = 32'd1;
        check_redirect("jal", 1'b1, 32'h0000_0060);
        tick("jal");
        check("jal_pc4_lit", PCPlus4M,            32'h44);
        check("jal_rs_lit",  {30'd0, ResultSrcM}, 32'd2);

        // Bubble: all-zero controls propagate with no writes.
        clear_inputs();
        RD1E = 32'h55; RD2E = 32'h66;
        tick("bubble");

        // Reset mid-stream over a valid store. The redirect path ignores reset.
        clear_inputs();
        reset = 1'b1;
        MemWriteE = 1'b1; RD1E = 32'h1000; RD2E = 32'hCAFE; ImmExtE = 32'h8; ALUSrcE = 1'b1;
        PCPlus4E = 32'h88; RdE = 5'd2; JumpE = 1'b1; PCE = 32'h300;
        check_redirect("rst_redirect", 1'b1, 32'h0000_0308);
        tick("rst_store");
        check("rst_mw_lit", {31'd0, MemWriteM}, 32'd0);

        // Loading resumes on the first edge after reset drops.
        reset = 1'b0;
        JumpE = 1'b0;
        tick("resume_store");
        check("resume_mw_lit", {31'd0, MemWriteM}, 32'd1);
        check("resume_wd_lit", WriteDataM,         32'h0000_CAFE);

        // Dependent back-to-back adds through the MEM forward path.
        clear_inputs();
        ForwardAE = 2'b10; ImmExtE = 32'd1; ALUSrcE = 1'b1; RegWriteE = 1'b1;
        for (int i = 0; i < 3; i++) tick("chain");

        check("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
